// File: rtl/shift_right_sequencer.sv
// Iterative right shifter (logical/arithmetic), one bit per cycle; optional ABORT port under SHIFT_RIGHT_SEQ_ABORT_EN.
// Latency: min(B,N) cycles from the START edge to the edge entering DONE (B=0 -> DONE right after capture).
// Backpressure: none; START is ignored while BUSY, no queueing.
module shift_right_sequencer #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic         TYPE,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef SHIFT_RIGHT_SEQ_ABORT_EN
    input  logic         ABORT,
`endif
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] OUT,
    output logic         OVERFLOW
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   work_q, work_d;
    logic           fill_q, fill_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic [N-1:0]   out_q, out_d;
    logic           overflow_q, overflow_d;

    logic           abort_req;
    logic           b_big;
    logic [CW-1:0]  k_load;
    logic [N-1:0]   work_shift;

`ifdef SHIFT_RIGHT_SEQ_ABORT_EN
    assign abort_req = ABORT;
`else
    assign abort_req = 1'b0;
`endif

    // Compare one bit wider so N itself is representable for any N.
    assign b_big      = ({1'b0, B} >= (N + 1)'(N));
    assign k_load     = b_big ? CW'(N) : CW'(B);
    assign work_shift = (work_q >> 1) | {fill_q, {(N - 1){1'b0}}};

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_d      = out_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    work_d = A;
                    fill_d = TYPE & A[N-1];
                    ovf_d  = b_big;
                    cnt_d  = k_load;
                    if (k_load == '0) begin
                        state_d    = S_DONE;
                        out_d      = A;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    work_d = work_shift;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d    = S_DONE;
                        out_d      = work_shift;
                        overflow_d = ovf_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            fill_q     <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = (state_q == S_DONE);
    assign OUT      = out_q;
    assign OVERFLOW = overflow_q;

endmodule
